axi_rresp_router: RTL and testbench
===================================

// Module: axi_rresp_router
// PURPOSE
//  Read-data (R) channel return path of the AXI bus: the other end of the AR-channel arbiter.
//  Arbitrates among three slave R channels (S0, S1, default slave S2) and locks each burst until RLAST.
//  Decodes the master from the extended ID and strips the master field before delivering the beat.
//  Sits between the slave-side R ports and the master-side R ports, one instance per interconnect.
// PARAMETERS
//  ID_BITS    4   master-side ID width (AXI_ID_BITS)
//  IDS_BITS   8   slave-side extended ID width (AXI_IDS_BITS); master field = id[IDS_BITS-1:ID_BITS]
//  DATA_BITS  32  R data width
// PORTS
//  clk              in   1          clock, all state on rising edge
//  rst              in   1          asynchronous, active-low reset
//  id_s{0,1,2}_i    in   IDS_BITS   slave RID (extended)
//  data_s{0,1,2}_i  in   DATA_BITS  slave RDATA
//  resp_s{0,1,2}_i  in   2          slave RRESP
//  last_s{0,1,2}_i  in   1          slave RLAST
//  valid_s{0,1,2}_i in   1          slave RVALID
//  ready_s{0,1,2}_o out  1          RREADY to slave
//  id_m{0,1,2}_o    out  ID_BITS    master RID (master field stripped)
//  data_m{0,1,2}_o  out  DATA_BITS  master RDATA
//  resp_m{0,1,2}_o  out  2          master RRESP
//  last_m{0,1,2}_o  out  1          master RLAST
//  valid_m{0,1,2}_o out  1          master RVALID
//  ready_m{0,1,2}_i in   1          RREADY from master
//  drop_o           out  1          1-cycle pulse: beat with undecodable master field sunk
// BEHAVIOUR
//  - Master decode: field 0->M0, 1->M1, 2->M2, any other value->SINK (ready_s=1, no master valid, beat dropped).
//  - State: IDLE / LOCK; registers: state, sel[1:0] (locked slave), rr[1:0] (round-robin start, 0..2).
//  - IDLE: grant = first slave with valid asserted, searching rr, rr+1, rr+2 (mod 3). No valid -> nothing routed.
//  - The granted slave is routed combinationally in the same cycle (zero latency; no buffering).
//    If the beat handshakes with last=1: stay IDLE, rr <= grant+1 (mod 3).
//    Otherwise: -> LOCK, sel <= grant. This also applies when the master is not ready, because
//    a presented RVALID must not be re-arbitrated.
//  - LOCK: only slave sel is routed; all other ready_s = 0. On handshake with last=1: -> IDLE, rr <= sel+1 (mod 3).
//  - Routing: the decoded master gets id = id_s[ID_BITS-1:0], data, resp, last, and valid = valid_s[sel].
//    ready_s[sel] = ready_m of the decoded master (1 for SINK). Non-selected master outputs are all 0.
//  - The master is re-decoded every beat from the current beat's ID; slaves hold a constant ID within a burst.
//  - drop_o = valid_s[sel] & SINK, registered; it pulses the cycle after each sunk beat.
//  - Handshake = valid & ready in the same cycle. Ready never depends on the router's own valid
//    beyond the decode above, so there is no combinational loop.
//  - Reset (async, any time, including mid-burst): state=IDLE, sel=0, rr=0, drop_o=0.
//    All ready_s/valid_m outputs = 0 while rst=0; an interrupted burst is abandoned, not resumed.
//  - Simultaneous valids: resolved only by rr. A slave waiting in IDLE is granted within 2 bursts (fairness bound).
//  - Back-to-back bursts from the same slave: allowed only if no other slave is valid at the IDLE decision.
// TESTING
//  1. S0 id=8'h1_5, len=4 burst, M1 ready=1 -> M1 sees 4 beats id=4'h5 with last on beat 4; M0/M2 valid=0; rr=1.
//  2. S0 and S1 valid the same cycle, rr=0 -> S0 burst (2 beats) completes first, then S1; ready_s1=0 during S0 burst.
//  3. M2 ready low for 3 cycles mid-burst, S2 source -> data held, no beat lost or duplicated, ready_s2 mirrors ready_m2.
//  4. S1 beat with master field 4'hF -> ready_s1=1, no valid_m*, drop_o=1 on the next cycle.
//  5. rst pulled low during beat 2 of a 4-beat S0 burst -> outputs 0 immediately;
//     after release, state=IDLE and rr=0; a new S1 burst is accepted.
//  6. All three slaves continuously valid, single-beat bursts -> grants rotate S0, S1, S2, S0 ...

Source files
------------

// File: rtl/axi_rresp_router.sv
// AXI R-channel return router: round-robin among three slave R channels with burst lock
// until RLAST, master decoded from the extended ID's upper field, that field stripped on delivery.
module axi_rresp_router #(
  parameter int ID_BITS   = 4,
  parameter int IDS_BITS  = 8,
  parameter int DATA_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IDS_BITS-1:0]  id_s0_i,
  input  logic [IDS_BITS-1:0]  id_s1_i,
  input  logic [IDS_BITS-1:0]  id_s2_i,
  input  logic [DATA_BITS-1:0] data_s0_i,
  input  logic [DATA_BITS-1:0] data_s1_i,
  input  logic [DATA_BITS-1:0] data_s2_i,
  input  logic [1:0]           resp_s0_i,
  input  logic [1:0]           resp_s1_i,
  input  logic [1:0]           resp_s2_i,
  input  logic                 last_s0_i,
  input  logic                 last_s1_i,
  input  logic                 last_s2_i,
  input  logic                 valid_s0_i,
  input  logic                 valid_s1_i,
  input  logic                 valid_s2_i,
  output logic                 ready_s0_o,
  output logic                 ready_s1_o,
  output logic                 ready_s2_o,
  output logic [ID_BITS-1:0]   id_m0_o,
  output logic [ID_BITS-1:0]   id_m1_o,
  output logic [ID_BITS-1:0]   id_m2_o,
  output logic [DATA_BITS-1:0] data_m0_o,
  output logic [DATA_BITS-1:0] data_m1_o,
  output logic [DATA_BITS-1:0] data_m2_o,
  output logic [1:0]           resp_m0_o,
  output logic [1:0]           resp_m1_o,
  output logic [1:0]           resp_m2_o,
  output logic                 last_m0_o,
  output logic                 last_m1_o,
  output logic                 last_m2_o,
  output logic                 valid_m0_o,
  output logic                 valid_m1_o,
  output logic                 valid_m2_o,
  input  logic                 ready_m0_i,
  input  logic                 ready_m1_i,
  input  logic                 ready_m2_i,
  output logic                 drop_o
);
  localparam int MF_BITS = IDS_BITS - ID_BITS;

  typedef enum logic {ST_IDLE, ST_LOCK} state_t;

  state_t r_state;
  logic [1:0] r_sel;
  logic [1:0] r_rr;
  logic       r_drop;

  logic [2:0]           w_vld;
  logic [1:0]           w_c1, w_c2;
  logic [1:0]           w_grant;
  logic                 w_any;
  logic                 w_act;
  logic [1:0]           w_cur;
  logic [IDS_BITS-1:0]  w_id;
  logic [DATA_BITS-1:0] w_data;
  logic [1:0]           w_resp;
  logic                 w_last;
  logic                 w_valid;
  logic [MF_BITS-1:0]   w_mf;
  logic [1:0]           w_dm;
  logic                 w_sink;
  logic                 w_rdy_m;
  logic                 w_rdy;
  logic                 w_hs;
  logic                 w_en;
  logic [2:0]           w_msel;

  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  assign w_vld = {valid_s2_i, valid_s1_i, valid_s0_i};
  assign w_c1  = inc3(r_rr);
  assign w_c2  = inc3(w_c1);

  // Round-robin search starting at r_rr; only consulted while IDLE.
  always_comb begin
    w_grant = r_rr;
    w_any   = 1'b1;
    if (w_vld[r_rr])      w_grant = r_rr;
    else if (w_vld[w_c1]) w_grant = w_c1;
    else if (w_vld[w_c2]) w_grant = w_c2;
    else                  w_any   = 1'b0;
  end

  assign w_act = (r_state == ST_LOCK) | w_any;
  assign w_cur = (r_state == ST_LOCK) ? r_sel : w_grant;

  always_comb begin
    case (w_cur)
      2'd0:    begin w_id = id_s0_i; w_data = data_s0_i; w_resp = resp_s0_i; w_last = last_s0_i; w_valid = valid_s0_i; end
      2'd1:    begin w_id = id_s1_i; w_data = data_s1_i; w_resp = resp_s1_i; w_last = last_s1_i; w_valid = valid_s1_i; end
      default: begin w_id = id_s2_i; w_data = data_s2_i; w_resp = resp_s2_i; w_last = last_s2_i; w_valid = valid_s2_i; end
    endcase
  end

  assign w_mf   = w_id[IDS_BITS-1:ID_BITS];
  assign w_dm   = w_mf[1:0];
  assign w_sink = (w_mf > MF_BITS'(2));

  always_comb begin
    case (w_dm)
      2'd0:    w_rdy_m = ready_m0_i;
      2'd1:    w_rdy_m = ready_m1_i;
      default: w_rdy_m = ready_m2_i;
    endcase
  end

  // Undecodable beats are accepted and discarded so the slave never stalls.
  assign w_rdy = w_sink | w_rdy_m;
  assign w_hs  = w_act & w_valid & w_rdy;
  assign w_en  = w_act & rst;

  assign ready_s0_o = w_en & (w_cur == 2'd0) & w_rdy;
  assign ready_s1_o = w_en & (w_cur == 2'd1) & w_rdy;
  assign ready_s2_o = w_en & (w_cur == 2'd2) & w_rdy;

  assign w_msel[0] = w_en & ~w_sink & (w_dm == 2'd0);
  assign w_msel[1] = w_en & ~w_sink & (w_dm == 2'd1);
  assign w_msel[2] = w_en & ~w_sink & (w_dm == 2'd2);

  assign valid_m0_o = w_msel[0] & w_valid;
  assign valid_m1_o = w_msel[1] & w_valid;
  assign valid_m2_o = w_msel[2] & w_valid;
  assign id_m0_o    = w_msel[0] ? w_id[ID_BITS-1:0] : '0;
  assign id_m1_o    = w_msel[1] ? w_id[ID_BITS-1:0] : '0;
  assign id_m2_o    = w_msel[2] ? w_id[ID_BITS-1:0] : '0;
  assign data_m0_o  = w_msel[0] ? w_data : '0;
  assign data_m1_o  = w_msel[1] ? w_data : '0;
  assign data_m2_o  = w_msel[2] ? w_data : '0;
  assign resp_m0_o  = w_msel[0] ? w_resp : 2'b00;
  assign resp_m1_o  = w_msel[1] ? w_resp : 2'b00;
  assign resp_m2_o  = w_msel[2] ? w_resp : 2'b00;
  assign last_m0_o  = w_msel[0] & w_last;
  assign last_m1_o  = w_msel[1] & w_last;
  assign last_m2_o  = w_msel[2] & w_last;
  assign drop_o     = r_drop;

  // A presented beat that does not complete the burst locks the slave, even if unaccepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_sel   <= 2'd0;
      r_rr    <= 2'd0;
      r_drop  <= 1'b0;
    end else begin
      r_drop <= w_act & w_valid & w_sink;
      if (w_act) begin
        if (w_hs & w_last) begin
          r_state <= ST_IDLE;
          r_rr    <= inc3(w_cur);
        end else begin
          r_state <= ST_LOCK;
          r_sel   <= w_cur;
        end
      end
    end
  end
endmodule

// File: tb/tb_axi_rresp_router.sv
// Bench for axi_rresp_router: directed cycle table, corner sequences, then random bursts
// compared against a burst-owner reference model.
module tb_axi_rresp_router;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  id_s   [3];
  logic [31:0] data_s [3];
  logic [1:0]  resp_s [3];
  logic        last_s [3];
  logic        valid_s[3];
  logic        ready_m[3];
  logic        ready_s0, ready_s1, ready_s2;
  logic [3:0]  id_m0, id_m1, id_m2;
  logic [31:0] data_m0, data_m1, data_m2;
  logic [1:0]  resp_m0, resp_m1, resp_m2;
  logic        last_m0, last_m1, last_m2;
  logic        valid_m0, valid_m1, valid_m2;
  logic        drop;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  axi_rresp_router #(.ID_BITS(4), .IDS_BITS(8), .DATA_BITS(32)) dut (
    .clk(clk), .rst(rst),
    .id_s0_i(id_s[0]), .id_s1_i(id_s[1]), .id_s2_i(id_s[2]),
    .data_s0_i(data_s[0]), .data_s1_i(data_s[1]), .data_s2_i(data_s[2]),
    .resp_s0_i(resp_s[0]), .resp_s1_i(resp_s[1]), .resp_s2_i(resp_s[2]),
    .last_s0_i(last_s[0]), .last_s1_i(last_s[1]), .last_s2_i(last_s[2]),
    .valid_s0_i(valid_s[0]), .valid_s1_i(valid_s[1]), .valid_s2_i(valid_s[2]),
    .ready_s0_o(ready_s0), .ready_s1_o(ready_s1), .ready_s2_o(ready_s2),
    .id_m0_o(id_m0), .id_m1_o(id_m1), .id_m2_o(id_m2),
    .data_m0_o(data_m0), .data_m1_o(data_m1), .data_m2_o(data_m2),
    .resp_m0_o(resp_m0), .resp_m1_o(resp_m1), .resp_m2_o(resp_m2),
    .last_m0_o(last_m0), .last_m1_o(last_m1), .last_m2_o(last_m2),
    .valid_m0_o(valid_m0), .valid_m1_o(valid_m1), .valid_m2_o(valid_m2),
    .ready_m0_i(ready_m[0]), .ready_m1_i(ready_m[1]), .ready_m2_i(ready_m[2]),
    .drop_o(drop)
  );

  logic [2:0]   vm, rs;
  logic [122:0] all_out;
  assign vm = {valid_m2, valid_m1, valid_m0};
  assign rs = {ready_s2, ready_s1, ready_s0};
  assign all_out = {vm, rs, id_m2, id_m1, id_m0, last_m2, last_m1, last_m0,
                    resp_m2, resp_m1, resp_m0, data_m2, data_m1, data_m0};

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    for (int s = 0; s < 3; s++) begin
      id_s[s] = 8'h0; data_s[s] = 32'h0; resp_s[s] = 2'b00;
      last_s[s] = 1'b0; valid_s[s] = 1'b0; ready_m[s] = 1'b1;
    end
  endtask

  typedef struct {
    logic [2:0]  vs;
    logic [2:0]  ls;
    logic [11:0] mf;
    logic [2:0]  rm;
    logic [2:0]  evm;
    logic [2:0]  ers;
  } vec_t;
  vec_t tv[16];

  // Reference model: burst ownership and round-robin pointer
  bit          m_lock;
  int          m_sel, m_rr;
  bit          exp_drop;
  bit          hs_prev[3];
  int          left[3];
  logic [3:0]  mf_cur[3], idl_cur[3];

  initial begin
    logic [31:0] dbeat[4];
    bit          rp[7];
    int          k;
    idle_inputs();

    // Reset holds all handshake outputs low even with valid slaves
    for (int s = 0; s < 3; s++) begin valid_s[s] = 1'b1; id_s[s] = {4'(s), 4'h1}; end
    #3;
    chk("rst_out", {vm, rs}, 6'b0);
    chk("rst_drop", drop, 1'b0);
    idle_inputs();
    @(negedge clk); rst = 1'b1;

    tv[0]  = '{3'b001, 3'b000, 12'h001, 3'b111, 3'b010, 3'b001};
    tv[1]  = '{3'b001, 3'b000, 12'h001, 3'b111, 3'b010, 3'b001};
    tv[2]  = '{3'b001, 3'b000, 12'h001, 3'b111, 3'b010, 3'b001};
    tv[3]  = '{3'b001, 3'b001, 12'h001, 3'b111, 3'b010, 3'b001};
    tv[4]  = '{3'b111, 3'b111, 12'h210, 3'b111, 3'b010, 3'b010};
    tv[5]  = '{3'b111, 3'b111, 12'h210, 3'b111, 3'b100, 3'b100};
    tv[6]  = '{3'b111, 3'b111, 12'h210, 3'b111, 3'b001, 3'b001};
    tv[7]  = '{3'b111, 3'b111, 12'h210, 3'b111, 3'b010, 3'b010};
    tv[8]  = '{3'b111, 3'b111, 12'h210, 3'b111, 3'b100, 3'b100};
    tv[9]  = '{3'b011, 3'b000, 12'h010, 3'b111, 3'b001, 3'b001};
    tv[10] = '{3'b011, 3'b001, 12'h010, 3'b111, 3'b001, 3'b001};
    tv[11] = '{3'b010, 3'b000, 12'h010, 3'b111, 3'b010, 3'b010};
    tv[12] = '{3'b010, 3'b010, 12'h010, 3'b111, 3'b010, 3'b010};
    tv[13] = '{3'b001, 3'b001, 12'h210, 3'b110, 3'b001, 3'b000};
    tv[14] = '{3'b101, 3'b101, 12'h210, 3'b111, 3'b001, 3'b001};
    tv[15] = '{3'b100, 3'b100, 12'h210, 3'b111, 3'b100, 3'b100};

    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      for (int s = 0; s < 3; s++) begin
        valid_s[s] = tv[i].vs[s];
        last_s[s]  = tv[i].ls[s];
        id_s[s]    = {tv[i].mf[s*4 +: 4], 4'h5};
        data_s[s]  = 32'hD0 + 32'(s);
        resp_s[s]  = 2'(s);
        ready_m[s] = tv[i].rm[s];
      end
      #3;
      chk($sformatf("vec%0d", i), {vm, rs}, {tv[i].evm, tv[i].ers});
      if (vm != 3'b000) chk($sformatf("vec%0d_id", i), id_m0 | id_m1 | id_m2, 4'h5);
    end

    // S2 burst to M2 with M2 stalling three cycles mid-burst
    idle_inputs();
    for (int b = 0; b < 4; b++) dbeat[b] = 32'h3000 + 32'(b);
    rp = '{1, 1, 0, 0, 0, 1, 1};
    k = 0;
    for (int c = 0; c < 7; c++) begin
      @(posedge clk); #1;
      valid_s[2] = 1'b1; id_s[2] = 8'h2A; data_s[2] = dbeat[k]; last_s[2] = (k == 3);
      ready_m[2] = rp[c];
      #3;
      chk("t3_valid", valid_m2, 1'b1);
      chk("t3_data", data_m2, dbeat[k]);
      chk("t3_ready", ready_s2, rp[c]);
      if (k == 3) chk("t3_last", last_m2, 1'b1);
      if (rp[c]) k++;
    end

    // Undecodable master field is sunk and flagged on the following cycle
    @(posedge clk); #1;
    idle_inputs();
    valid_s[1] = 1'b1; id_s[1] = 8'hF3; last_s[1] = 1'b1; data_s[1] = 32'hBAD;
    #3;
    chk("t4_ready", rs, 3'b010);
    chk("t4_novalid", vm, 3'b000);
    chk("t4_drop_pre", drop, 1'b0);
    @(posedge clk); #1;
    valid_s[1] = 1'b0;
    chk("t4_drop", drop, 1'b1);
    @(posedge clk); #1;
    chk("t4_drop_end", drop, 1'b0);

    // Reset during beat 2 of an S0 burst; afterwards rr must be back at 0
    valid_s[0] = 1'b1; id_s[0] = 8'h07; last_s[0] = 1'b0; data_s[0] = 32'h51;
    #3;
    chk("t5_beat1", {vm, rs}, {3'b001, 3'b001});
    @(posedge clk); #1;
    data_s[0] = 32'h52;
    #1;
    chk("t5_beat2", {vm, rs}, {3'b001, 3'b001});
    rst = 1'b0;
    #1;
    chk("t5_rst_now", {vm, rs}, 6'b0);
    @(posedge clk); #1;
    chk("t5_rst_hold", {vm, rs, drop}, 7'b0);
    valid_s[0] = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    valid_s[1] = 1'b1; id_s[1] = 8'h16; last_s[1] = 1'b1;
    valid_s[2] = 1'b1; id_s[2] = 8'h26; last_s[2] = 1'b1;
    #3;
    chk("t5_after", {vm, rs}, {3'b010, 3'b010});

    // Random bursts against the reference model, from a fresh reset
    @(posedge clk); #1;
    idle_inputs();
    rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    m_lock = 0; m_sel = 0; m_rr = 0; exp_drop = 0;
    for (int s = 0; s < 3; s++) begin hs_prev[s] = 0; left[s] = 0; mf_cur[s] = 0; idl_cur[s] = 0; end
    for (int cyc = 0; cyc < 2000; cyc++) begin
      int          owner, mfv;
      bit          sink, rdy, hs;
      logic [2:0]  evm, ers;
      logic [3:0]  eid[3];
      logic [31:0] edat[3];
      logic [1:0]  eresp[3];
      logic [2:0]  elast;
      @(posedge clk); #1;
      chk("rnd_drop", drop, exp_drop);
      for (int s = 0; s < 3; s++) begin
        if (valid_s[s] && hs_prev[s]) valid_s[s] = 1'b0;
        if (!valid_s[s] && $urandom_range(0, 2) != 0) begin
          if (left[s] == 0) begin
            left[s] = $urandom_range(1, 4);
            mf_cur[s] = 4'($urandom_range(0, 4));
            idl_cur[s] = 4'($urandom);
          end
          valid_s[s] = 1'b1;
          id_s[s] = {mf_cur[s], idl_cur[s]};
          data_s[s] = $urandom;
          resp_s[s] = 2'($urandom);
          last_s[s] = (left[s] == 1);
        end
      end
      for (int m = 0; m < 3; m++) ready_m[m] = ($urandom_range(0, 3) != 0);

      owner = -1;
      if (m_lock) owner = m_sel;
      else for (int j = 0; j < 3; j++) if (owner < 0 && valid_s[(m_rr + j) % 3]) owner = (m_rr + j) % 3;
      evm = 0; ers = 0; elast = 0; sink = 0; rdy = 0;
      for (int m = 0; m < 3; m++) begin eid[m] = 0; edat[m] = 0; eresp[m] = 0; end
      if (owner >= 0) begin
        mfv  = int'(id_s[owner][7:4]);
        sink = (mfv > 2);
        rdy  = sink ? 1'b1 : ready_m[mfv];
        ers[owner] = rdy;
        if (!sink) begin
          evm[mfv]   = valid_s[owner];
          eid[mfv]   = id_s[owner][3:0];
          edat[mfv]  = data_s[owner];
          eresp[mfv] = resp_s[owner];
          elast[mfv] = last_s[owner];
        end
      end
      #3;
      chk("rnd_out", all_out, {evm, ers, eid[2], eid[1], eid[0], elast, eresp[2], eresp[1], eresp[0],
                               edat[2], edat[1], edat[0]});

      hs = (owner >= 0) && valid_s[owner] && rdy;
      for (int s = 0; s < 3; s++) hs_prev[s] = hs && (s == owner);
      exp_drop = (owner >= 0) && valid_s[owner] && sink;
      if (owner >= 0) begin
        if (hs) left[owner]--;
        if (hs && last_s[owner]) begin m_lock = 0; m_rr = (owner + 1) % 3; end
        else begin m_lock = 1; m_sel = owner; end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
